axi_outstanding_limiter: RTL and testbench
==========================================

Name: axi_outstanding_limiter

Overview:
- Sits directly downstream of the cache subsystem's merged AXI master port (ariane_axi::req_t/resp_t), before the SoC interconnect.
- Counts outstanding read and write transactions and throttles new AR/AW once a configured limit is reached.
- Provides a drain handshake so fence/flush logic can wait until all memory traffic has retired.
- Raises sticky error flags on protocol underflow.

Parameters:
- MaxRd, 4, maximum outstanding read bursts (AR accepted, last R not yet seen); 1..15
- MaxWr, 4, maximum outstanding write bursts (AW accepted, B not yet seen); 1..15
- CntWidth, 4, counter width; must hold MaxRd and MaxWr
- TimeoutCycles, 1024, watchdog threshold (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  ariane_axi::req_t  request from the cache subsystem
- slv_resp_o  out  ariane_axi::resp_t  response to the cache subsystem
- mst_req_o  out  ariane_axi::req_t  request to the interconnect
- mst_resp_i  in  ariane_axi::resp_t  response from the interconnect
- drain_i  in  1  block new AR/AW and wait for outstanding traffic to retire
- drained_o  out  1  drain complete: no outstanding reads or writes
- rd_outstanding_o  out  CntWidth  current read count
- wr_outstanding_o  out  CntWidth  current write count
- err_underflow_o  out  1  sticky: R-last or B arrived with the matching counter at 0
- timeout_o  out  2  sticky [1]=write, [0]=read watchdog expiry (only with the optional feature; tied 0 otherwise)

Behaviour:
- Reset is asynchronous, active-low. On reset: counters=0, FSM=RUN, drained_o=0, err_underflow_o=0, timeout_o=0.
- Pass-through: all payload fields and all W/R/B valid/ready signals are combinational, with zero latency.
- ar_allow = (rd_cnt < MaxRd) & (state==RUN).
  - mst_req_o.ar_valid = slv_req_i.ar_valid & ar_allow
  - slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow
- aw_allow is defined the same way using wr_cnt and MaxWr.
- ar_allow and aw_allow depend only on registers. There is no combinational valid-to-ready path.
- Read counter update:
  - inc on mst AR handshake
  - dec on mst R handshake with r.last
  - inc and dec in the same cycle: count unchanged
  - dec at 0 with no inc: count stays 0 and err_underflow_o is set
- Write counter update: inc on mst AW handshake, dec on mst B handshake. Same rules as the read counter.
- W beats are not counted. W ordering remains the upstream block's responsibility.
- A counter never exceeds its Max, because the gate closes in the cycle the count equals Max.
- When the gate closes while AR valid is already asserted upstream, the request is held (not dropped). The AXI valid-stability rule holds because upstream keeps valid high.
- FSM states:
  - RUN: gates open per the limits.
    - drain_i=1 and both counts 0 -> DRAINED
    - drain_i=1 otherwise -> DRAIN
  - DRAIN: gates closed.
    - both counts reach 0 (evaluated on next-state counts) -> DRAINED
    - drain_i=0 -> RUN
  - DRAINED: gates closed, drained_o=1.
    - drain_i=0 -> RUN
- drained_o is registered (asserted only in DRAINED).
- Draining with a handshake already in flight: that AR/AW cycle completes only if ar_allow was 1 in that cycle, i.e. the state was still RUN.
- err_underflow_o clears only on reset.

Optional Feature:
- Macro: AXI_OUTSTANDING_TIMEOUT_EN.
- When defined:
  - Two CntWidth-independent $clog2(TimeoutCycles+1)-bit watchdogs, one read and one write.
  - Each increments while its count>0 and no R-last/B handshake occurs that cycle.
  - Each resets to 0 on that handshake or when its count is 0.
  - Reaching TimeoutCycles sets the matching timeout_o bit (sticky until reset). Traffic is unaffected.
- When not defined: no watchdog logic, and timeout_o is tied 2'b00.

Decomposition:
- Add the FSM typedef (RUN/DRAIN/DRAINED) to std_cache_pkg as outst_state_e.
- Add default limit localparams to std_cache_pkg.
- One sub-module, axi_txn_counter: saturating up/down counter with limit compare and underflow flag, instantiated once for reads and once for writes.

Test Plan:
- MaxRd=4, 5 back-to-back ARs with mst ar_ready=1 and no R -> 4 accepted, 5th held with slv ar_ready=0, rd_outstanding_o=4. One R with last=1 -> 5th accepted the next cycle.
- AR handshake and R-last in the same cycle at rd_cnt=2 -> rd_cnt stays 2 and err_underflow_o=0.
- 2 writes outstanding, drain_i=1 -> aw_valid is blocked downstream and drained_o=0. After both Bs, drained_o=1 one cycle later. drain_i=0 -> RUN, and a new AW passes.
- Unsolicited B at wr_cnt=0 -> err_underflow_o=1 (sticky), wr_cnt=0.
- rst_ni asserted low mid-burst with rd_cnt=3 -> all outputs reset asynchronously, counts 0, FSM=RUN.
- With AXI_OUTSTANDING_TIMEOUT_EN and TimeoutCycles=16: one AR, R withheld for 16 cycles -> timeout_o=2'b01. With the macro undefined -> timeout_o stays 0.

Source files
------------

// File: rtl/axi_outstanding_limiter_pkg.sv
// Shared types and defaults for the AXI outstanding-transaction limiter.
//
// Contents:
//   - AXI channel and request/response structs. This is a trimmed ariane_axi
//     style req_t/resp_t, kept local so the slice builds on its own.
//   - outst_state_e : limiter FSM states (RUN / DRAIN / DRAINED).
//   - Default limit localparams used as the limiter's parameter defaults.
package axi_outstanding_limiter_pkg;

  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  localparam int unsigned DefaultMaxRd         = 4;
  localparam int unsigned DefaultMaxWr         = 4;
  localparam int unsigned DefaultCntWidth      = 4;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } outst_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ax_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_outstanding_limiter_counter.sv
// axi_txn_counter: up/down counter of outstanding bursts.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : burst accepted this cycle
//   dec         : burst retired this cycle
//   cnt         : registered count
//   cnt_next    : count after this cycle's update (for look-ahead decisions)
//   below_max   : cnt < Max, i.e. another burst may be accepted
//   underflow   : sticky, set when a retire arrives with the count at 0
module axi_txn_counter #(
  parameter int unsigned Max      = 4,
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                dec,
  output logic [CntWidth-1:0] cnt,
  output logic [CntWidth-1:0] cnt_next,
  output logic                below_max,
  output logic                underflow
);

  localparam logic [CntWidth-1:0] MaxVal = CntWidth'(Max);

  logic uf_hit;

  always_comb begin
    cnt_next = cnt;
    uf_hit   = 1'b0;
    case ({inc, dec})
      2'b10: if (cnt != MaxVal) cnt_next = cnt + CntWidth'(1);
      2'b01: begin
        // A retire with nothing outstanding is a protocol error; hold at 0.
        if (cnt == '0) uf_hit = 1'b1;
        else           cnt_next = cnt - CntWidth'(1);
      end
      default: cnt_next = cnt;
    endcase
  end

  assign below_max = (cnt < MaxVal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      underflow <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      underflow <= underflow | uf_hit;
    end
  end

endmodule

// File: rtl/axi_outstanding_limiter.sv
// axi_outstanding_limiter: caps outstanding AXI read/write bursts between the
// cache subsystem and the interconnect, with a drain handshake for fences.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   slv_req_i/slv_resp_o   : upstream (cache) side
//   mst_req_o/mst_resp_i   : downstream (interconnect) side
//   drain_i                : block new AR/AW and wait for traffic to retire
//   drained_o              : registered, high only in DRAINED
//   rd/wr_outstanding_o    : current outstanding burst counts
//   err_underflow_o        : sticky, R-last or B with its counter at 0
//   timeout_o              : sticky watchdog expiry {write, read}
//
// Optional feature: define AXI_OUTSTANDING_TIMEOUT_EN to build the per-channel
// watchdogs; otherwise timeout_o is tied to 2'b00.
module axi_outstanding_limiter
  import axi_outstanding_limiter_pkg::*;
#(
  parameter int unsigned MaxRd         = DefaultMaxRd,
  parameter int unsigned MaxWr         = DefaultMaxWr,
  parameter int unsigned CntWidth      = DefaultCntWidth,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  req_t                slv_req_i,
  output resp_t               slv_resp_o,
  output req_t                mst_req_o,
  input  resp_t               mst_resp_i,
  input  logic                drain_i,
  output logic                drained_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  output logic                err_underflow_o,
  output logic [1:0]          timeout_o
);

  if (MaxRd < 1 || MaxRd > 15 || MaxWr < 1 || MaxWr > 15 ||
      MaxRd > (2**CntWidth) - 1 || MaxWr > (2**CntWidth) - 1 ||
      TimeoutCycles < 1) begin : g_bad_cfg
    $error("axi_outstanding_limiter: illegal parameter combination");
  end

  outst_state_e        state;
  logic                drained;
  logic [CntWidth-1:0] rd_cnt, rd_cnt_next, wr_cnt, wr_cnt_next;
  logic                rd_below, wr_below, rd_uf, wr_uf;
  logic                ar_allow, aw_allow;
  logic                ar_hs, aw_hs, r_last_hs, b_hs;

  // Gates depend only on registers, so there is no valid-to-ready loop.
  assign ar_allow = rd_below & (state == RUN);
  assign aw_allow = wr_below & (state == RUN);

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_allow;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_allow;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_allow;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_allow;
  end

  assign ar_hs     = slv_req_i.ar_valid & ar_allow & mst_resp_i.ar_ready;
  assign aw_hs     = slv_req_i.aw_valid & aw_allow & mst_resp_i.aw_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  axi_txn_counter #(.Max(MaxRd), .CntWidth(CntWidth)) i_rd_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(ar_hs), .dec(r_last_hs),
    .cnt(rd_cnt), .cnt_next(rd_cnt_next), .below_max(rd_below), .underflow(rd_uf)
  );

  axi_txn_counter #(.Max(MaxWr), .CntWidth(CntWidth)) i_wr_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(aw_hs), .dec(b_hs),
    .cnt(wr_cnt), .cnt_next(wr_cnt_next), .below_max(wr_below), .underflow(wr_uf)
  );

  // Idle is judged on next-state counts so a handshake landing in the same
  // cycle as the drain request is not mistaken for an empty pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (drain_i) begin
            if (rd_cnt_next == '0 && wr_cnt_next == '0) begin
              state   <= DRAINED;
              drained <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_cnt_next == '0 && wr_cnt_next == '0) begin
            state   <= DRAINED;
            drained <= 1'b1;
          end else if (!drain_i) begin
            state <= RUN;
          end
        end
        DRAINED: begin
          if (!drain_i) begin
            state   <= RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

  assign drained_o        = drained;
  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  assign err_underflow_o  = rd_uf | wr_uf;

`ifdef AXI_OUTSTANDING_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TimeoutCycles);

  logic [WdWidth-1:0] rd_wd, rd_wd_next, wr_wd, wr_wd_next;
  logic [1:0]         timeout_q;

  // Watchdogs measure time since the last retire while anything is pending;
  // they saturate at the limit so the sticky flag cannot be re-armed by wrap.
  always_comb begin
    rd_wd_next = rd_wd;
    if (r_last_hs || rd_cnt == '0) rd_wd_next = '0;
    else if (rd_wd != WdLimit)     rd_wd_next = rd_wd + WdWidth'(1);
    wr_wd_next = wr_wd;
    if (b_hs || wr_cnt == '0)      wr_wd_next = '0;
    else if (wr_wd != WdLimit)     wr_wd_next = wr_wd + WdWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_wd     <= '0;
      wr_wd     <= '0;
      timeout_q <= 2'b00;
    end else begin
      rd_wd     <= rd_wd_next;
      wr_wd     <= wr_wd_next;
      timeout_q <= timeout_q | {(wr_wd_next == WdLimit), (rd_wd_next == WdLimit)};
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 2'b00;
`endif

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed, table-driven bench for axi_outstanding_limiter (MaxRd=MaxWr=4,
// TimeoutCycles=16). Each step drives inputs after the falling edge, checks
// the combinational gates, then checks registered state after the rising edge.
module tb_axi_outstanding_limiter;
  import axi_outstanding_limiter_pkg::*;

  logic       clk;
  logic       rst_n;
  req_t       slv_req;
  resp_t      slv_resp;
  req_t       mst_req;
  resp_t      mst_resp;
  logic       drain;
  logic       drained;
  logic [3:0] rd_cnt;
  logic [3:0] wr_cnt;
  logic       err;
  logic [1:0] timeout;

  int total = 0;
  int bad   = 0;

  axi_outstanding_limiter #(
    .MaxRd(4), .MaxWr(4), .CntWidth(4), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .drain_i(drain), .drained_o(drained),
    .rd_outstanding_o(rd_cnt), .wr_outstanding_o(wr_cnt),
    .err_underflow_o(err), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {ar_valid, aw_valid, ar_ready, aw_ready, r_valid, r_last, b_valid, drain}
  // g  = expected {mst ar_valid, slv ar_ready, mst aw_valid, slv aw_ready}
  // de = expected {drained, err_underflow} after the edge
  typedef struct {
    logic [7:0] in;
    logic [3:0] g;
    int         rd;
    int         wr;
    logic [1:0] de;
  } vec_t;

  vec_t vecs[$];

  localparam logic [7:0] I_NONE = 8'b0000_0000;
  localparam logic [7:0] I_AR   = 8'b1010_0000;
  localparam logic [7:0] I_ARRL = 8'b1010_1100;
  localparam logic [7:0] I_RL   = 8'b0000_1100;
  localparam logic [7:0] I_RNL  = 8'b0000_1000;
  localparam logic [7:0] I_AW   = 8'b0101_0000;
  localparam logic [7:0] I_AWB  = 8'b0101_0010;
  localparam logic [7:0] I_AWD  = 8'b0101_0001;
  localparam logic [7:0] I_ALLD = 8'b1111_0001;
  localparam logic [7:0] I_BD   = 8'b0000_0011;
  localparam logic [7:0] I_B    = 8'b0000_0010;
  localparam logic [7:0] I_D    = 8'b0000_0001;
  localparam logic [7:0] I_AWNR = 8'b0100_0000;

  task automatic add(input logic [7:0] in, input logic [3:0] g,
                     input int rd, input int wr, input logic [1:0] de);
    vec_t v;
    v.in = in; v.g = g; v.rd = rd; v.wr = wr; v.de = de;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in);
    slv_req.ar_valid   = in[7];
    slv_req.aw_valid   = in[6];
    mst_resp.ar_ready  = in[5];
    mst_resp.aw_ready  = in[4];
    mst_resp.r_valid   = in[3];
    mst_resp.r.last    = in[2];
    mst_resp.b_valid   = in[1];
    drain              = in[0];
  endtask

  task automatic step(input string tag, input logic [7:0] in, input logic [3:0] g,
                      input int rd, input int wr, input logic [1:0] de);
    @(negedge clk);
    drive(in);
    #1;
    chk({tag, "_mst_arv"}, mst_req.ar_valid, g[3]);
    chk({tag, "_slv_arr"}, slv_resp.ar_ready, g[2]);
    chk({tag, "_mst_awv"}, mst_req.aw_valid, g[1]);
    chk({tag, "_slv_awr"}, slv_resp.aw_ready, g[0]);
    @(posedge clk);
    #1;
    chk({tag, "_rd"}, rd_cnt, rd);
    chk({tag, "_wr"}, wr_cnt, wr);
    chk({tag, "_drained"}, drained, de[1]);
    chk({tag, "_err"}, err, de[0]);
  endtask

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    slv_req.ar.addr = 64'h0000_1234_5678_9ABC;
    mst_resp.r.data = 64'hDEAD_BEEF_0BAD_F00D;
    drain = 1'b0;
    rst_n = 1'b0;

    // Limit fill and release, simultaneous inc/dec, non-last beats
    for (int i = 0; i < 4; i++) add(I_AR, 4'b1100, i + 1, 0, 2'b00);
    add(I_AR,   4'b0000, 4, 0, 2'b00);
    add(I_ARRL, 4'b0000, 3, 0, 2'b00);
    add(I_AR,   4'b1100, 4, 0, 2'b00);
    add(I_RL,   4'b0000, 3, 0, 2'b00);
    add(I_RL,   4'b0000, 2, 0, 2'b00);
    add(I_ARRL, 4'b1100, 2, 0, 2'b00);
    add(I_RNL,  4'b0000, 2, 0, 2'b00);
    add(I_RL,   4'b0000, 1, 0, 2'b00);
    add(I_RL,   4'b0000, 0, 0, 2'b00);
    // Writes, then drain with an AW handshake in the drain-request cycle
    add(I_AW,   4'b0011, 0, 1, 2'b00);
    add(I_AW,   4'b0011, 0, 2, 2'b00);
    add(I_AWB,  4'b0011, 0, 2, 2'b00);
    add(I_AWD,  4'b0011, 0, 3, 2'b00);
    add(I_ALLD, 4'b0000, 0, 3, 2'b00);
    add(I_BD,   4'b0000, 0, 2, 2'b00);
    add(I_BD,   4'b0000, 0, 1, 2'b00);
    add(I_BD,   4'b0000, 0, 0, 2'b10);
    add(I_ALLD, 4'b0000, 0, 0, 2'b10);
    add(I_AWNR, 4'b0000, 0, 0, 2'b00);
    add(I_AW,   4'b0011, 0, 1, 2'b00);
    add(I_B,    4'b0000, 0, 0, 2'b00);
    // Unsolicited B, sticky error, idle drain straight to DRAINED
    add(I_B,    4'b0000, 0, 0, 2'b01);
    add(I_NONE, 4'b0000, 0, 0, 2'b01);
    add(I_D,    4'b0000, 0, 0, 2'b11);
    add(I_NONE, 4'b0000, 0, 0, 2'b01);

    #12;
    chk("rst_rd", rd_cnt, 0);
    chk("rst_wr", wr_cnt, 0);
    chk("rst_drained", drained, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("pass_ar_addr", mst_req.ar.addr, 64'h0000_1234_5678_9ABC);
    chk("pass_r_data", slv_resp.r.data, 64'hDEAD_BEEF_0BAD_F00D);
    chk("pass_r_ready", mst_req.r_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i].in, vecs[i].g,
                           vecs[i].rd, vecs[i].wr, vecs[i].de);

    // Asynchronous reset mid-burst with three reads outstanding
    step("a0", I_AR, 4'b1100, 1, 0, 2'b01);
    step("a1", I_AR, 4'b1100, 2, 0, 2'b01);
    step("a2", I_AR, 4'b1100, 3, 0, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd", rd_cnt, 0);
    chk("arst_wr", wr_cnt, 0);
    chk("arst_err", err, 0);
    chk("arst_drained", drained, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_gate_open", mst_req.ar_valid, 1);
    @(negedge clk);
    drive(I_NONE);
    rst_n = 1'b1;

    // Read-side underflow
    step("u0", I_RL,   4'b0000, 0, 0, 2'b01);
    step("u1", I_NONE, 4'b0000, 0, 0, 2'b01);

    // Watchdog: one read accepted, R withheld
    step("t0", I_AR, 4'b1100, 1, 0, 2'b01);
`ifdef AXI_OUTSTANDING_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step("tw", I_NONE, 4'b0000, 1, 0, 2'b01);
    chk("timeout_before", timeout, 2'b00);
    step("tx", I_NONE, 4'b0000, 1, 0, 2'b01);
    chk("timeout_rd", timeout, 2'b01);
`else
    for (int i = 0; i < 20; i++) step("tw", I_NONE, 4'b0000, 1, 0, 2'b01);
    chk("timeout_off", timeout, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
